// File: rtl/shift_loader.sv
`default_nettype none
// ============================================================================
// Module   : shift_loader
// Purpose  : Serial-to-parallel front end for the shift datapath. Collects a
//            framed single-bit stream into a WIDTH-bit word and presents it
//            as the 'a' operand with a valid/ready handshake. Partial frames
//            and dropped words are reported through sticky status flags.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            i_din           - serial data bit (qualified by i_din_valid)
//            i_din_valid     - i_din qualifier
//            i_sof           - start of frame, marks i_din as first bit
//            i_a_ready       - downstream accepts o_a when o_a_valid=1
//            i_err_clr       - clears o_overrun and o_frame_err
//            o_a             - assembled word, held while pending
//            o_a_valid       - word pending
//            o_busy          - frame in progress
//            o_bit_cnt       - bits collected in the current frame
//            o_overrun       - sticky: a completed word was dropped
//            o_frame_err     - sticky: sof arrived mid-frame
// Revision : 1.0 - initial release
// ============================================================================
module shift_loader #(
    parameter int               WIDTH     = 8,
    parameter bit               MSB_FIRST = 1'b1,
    parameter logic [WIDTH-1:0] RESET_VAL = 8'b11110000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_din,
    input  logic                       i_din_valid,
    input  logic                       i_sof,
    input  logic                       i_a_ready,
    input  logic                       i_err_clr,
    output logic [WIDTH-1:0]           o_a,
    output logic                       o_a_valid,
    output logic                       o_busy,
    output logic [$clog2(WIDTH+1)-1:0] o_bit_cnt,
    output logic                       o_overrun,
    output logic                       o_frame_err
);

    localparam int               c_CNT_W     = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_WIDTH = c_CNT_W'(WIDTH);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SHIFT = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [WIDTH-1:0]   r_sreg;
    logic [WIDTH-1:0]   r_a;
    logic               r_a_valid;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic               r_overrun;
    logic               r_frame_err;

    logic               w_start;
    logic               w_take;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               w_complete;
    logic [WIDTH-1:0]   w_base;
    logic [WIDTH-1:0]   w_shifted;
    logic               w_load_a;
    logic               w_set_ovr;
    logic               w_set_fe;

    // A qualified sof always starts a frame; plain bits count only mid-frame.
    assign w_start   = i_din_valid & i_sof;
    assign w_take    = i_din_valid & (i_sof | (r_state == c_ST_SHIFT));
    assign w_cnt_inc = w_start ? c_CNT_ONE : (r_bit_cnt + c_CNT_ONE);
    assign w_complete = w_take & (w_cnt_inc == c_CNT_WIDTH);

    // A restart begins from an empty register so no stale bits survive.
    assign w_base = w_start ? '0 : r_sreg;

    generate
        if (WIDTH == 1) begin : g_w1
            assign w_shifted = i_din;
        end else if (MSB_FIRST) begin : g_msb
            assign w_shifted = (w_base << 1) | {{(WIDTH-1){1'b0}}, i_din};
        end else begin : g_lsb
            assign w_shifted = (w_base >> 1) | {i_din, {(WIDTH-1){1'b0}}};
        end
    endgenerate

    // A completed word is accepted if the output slot is free or is being
    // emptied on this very edge; otherwise it is dropped.
    assign w_load_a  = w_complete & (~r_a_valid | i_a_ready);
    assign w_set_ovr = w_complete & r_a_valid & ~i_a_ready;
    assign w_set_fe  = w_start & (r_state == c_ST_SHIFT);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_take) begin
            w_state_nxt = w_complete ? c_ST_IDLE : c_ST_SHIFT;
        end
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sreg      <= '0;
            r_bit_cnt   <= '0;
            r_a         <= RESET_VAL;
            r_a_valid   <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_take) begin
                r_sreg    <= w_shifted;
                r_bit_cnt <= w_complete ? '0 : w_cnt_inc;
            end

            if (w_load_a) begin
                r_a       <= w_shifted;
                r_a_valid <= 1'b1;
            end else if (r_a_valid & i_a_ready) begin
                r_a_valid <= 1'b0;
            end

            // Set has priority over a simultaneous clear.
            r_overrun   <= w_set_ovr | (r_overrun   & ~i_err_clr);
            r_frame_err <= w_set_fe  | (r_frame_err & ~i_err_clr);
        end
    end

    assign o_a         = r_a;
    assign o_a_valid   = r_a_valid;
    assign o_busy      = (r_state == c_ST_SHIFT);
    assign o_bit_cnt   = r_bit_cnt;
    assign o_overrun   = r_overrun;
    assign o_frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_shift_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_loader
// Purpose  : Self-checking bench for shift_loader. Two instances (MSB-first
//            and LSB-first) share one stimulus stream. A frame-level model
//            queues expected words; per-DUT monitors pop and compare them
//            whenever a new word is presented.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       din = 1'b0;
    logic       din_valid = 1'b0;
    logic       sof = 1'b0;
    logic       a_ready = 1'b0;
    logic       err_clr = 1'b0;

    logic [7:0] a_m, a_l;
    logic       av_m, av_l, busy_m, busy_l, ovr_m, ovr_l, fe_m, fe_l;
    logic [3:0] cnt_m, cnt_l;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit         mbits[$];
    logic       mpend = 1'b0;
    logic       movr  = 1'b0;
    logic       mfe   = 1'b0;
    logic [7:0] qm[$];
    logic [7:0] ql[$];

    always #5 clk = ~clk;

    shift_loader #(.WIDTH(8), .MSB_FIRST(1'b1), .RESET_VAL(8'b11110000)) dut_m (
        .clk(clk), .rst(rst), .i_din(din), .i_din_valid(din_valid), .i_sof(sof),
        .i_a_ready(a_ready), .i_err_clr(err_clr), .o_a(a_m), .o_a_valid(av_m),
        .o_busy(busy_m), .o_bit_cnt(cnt_m), .o_overrun(ovr_m), .o_frame_err(fe_m)
    );

    shift_loader #(.WIDTH(8), .MSB_FIRST(1'b0), .RESET_VAL(8'b11110000)) dut_l (
        .clk(clk), .rst(rst), .i_din(din), .i_din_valid(din_valid), .i_sof(sof),
        .i_a_ready(a_ready), .i_err_clr(err_clr), .o_a(a_l), .o_a_valid(av_l),
        .o_busy(busy_l), .o_bit_cnt(cnt_l), .o_overrun(ovr_l), .o_frame_err(fe_l)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, advance the model, check after the edge.
    task automatic cycle(input logic dv, input logic d, input logic s,
                         input logic rdy, input logic clr, input logic r);
        logic       fire, so, sf, comp;
        logic [7:0] wm, wl;
        din = d; din_valid = dv; sof = s; a_ready = rdy; err_clr = clr; rst = r;
        so = 1'b0; sf = 1'b0; comp = 1'b0; wm = '0; wl = '0;
        if (r) begin
            mbits.delete(); mpend = 1'b0; movr = 1'b0; mfe = 1'b0;
            qm.delete(); ql.delete();
        end else begin
            fire = mpend & rdy;
            if (dv) begin
                if (s) begin
                    if (mbits.size() != 0) sf = 1'b1;
                    mbits.delete();
                    mbits.push_back(d);
                end else if (mbits.size() != 0) begin
                    mbits.push_back(d);
                end
            end
            if (mbits.size() == 8) begin
                comp = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    wm[7-i] = mbits[i];
                    wl[i]   = mbits[i];
                end
                mbits.delete();
            end
            if (comp) begin
                if (!mpend || rdy) begin
                    qm.push_back(wm);
                    ql.push_back(wl);
                    mpend = 1'b1;
                end else begin
                    so = 1'b1;
                end
            end else if (fire) begin
                mpend = 1'b0;
            end
            movr = so | (movr & ~clr);
            mfe  = sf | (mfe  & ~clr);
        end
        @(posedge clk);
        @(negedge clk);
        chk("bit_cnt_m", 32'(cnt_m), 32'(mbits.size()));
        chk("bit_cnt_l", 32'(cnt_l), 32'(mbits.size()));
        chk("busy_m", 32'(busy_m), 32'(mbits.size() != 0));
        chk("busy_l", 32'(busy_l), 32'(mbits.size() != 0));
        chk("a_valid_m", 32'(av_m), 32'(mpend));
        chk("a_valid_l", 32'(av_l), 32'(mpend));
        chk("overrun_m", 32'(ovr_m), 32'(movr));
        chk("overrun_l", 32'(ovr_l), 32'(movr));
        chk("frame_err_m", 32'(fe_m), 32'(mfe));
        chk("frame_err_l", 32'(fe_l), 32'(mfe));
        #1;
    endtask

    // Send the first n bits of w, MSB of w first, sof on the first bit.
    task automatic send(input logic [7:0] w, input int n, input logic rdy_rest,
                        input logic rdy_last);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, w[7-i], (i == 0), (i == n-1) ? rdy_last : rdy_rest, 1'b0, 1'b0);
        end
    endtask

    // ------------------------------------------------------------ monitors
    logic       pv_m = 1'b0, pv_l = 1'b0;
    logic [7:0] held_m = '0, held_l = '0;

    always @(negedge clk) begin
        if (av_m) begin
            if (!pv_m || a_ready) begin
                if (qm.size() == 0) chk("unexpected_word_m", 32'(a_m), 32'hFFFF_FFFF);
                else chk("word_m", 32'(a_m), 32'(qm.pop_front()));
                held_m = a_m;
            end else begin
                chk("hold_m", 32'(a_m), 32'(held_m));
            end
        end
        pv_m = av_m;
    end

    always @(negedge clk) begin
        if (av_l) begin
            if (!pv_l || a_ready) begin
                if (ql.size() == 0) chk("unexpected_word_l", 32'(a_l), 32'hFFFF_FFFF);
                else chk("word_l", 32'(a_l), 32'(ql.pop_front()));
                held_l = a_l;
            end else begin
                chk("hold_l", 32'(a_l), 32'(held_l));
            end
        end
        pv_l = av_l;
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        // reset
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("reset_a_m", 32'(a_m), 32'hF0);
        chk("reset_a_l", 32'(a_l), 32'hF0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // basic frame 1,0,1,1,0,0,1,0
        send(8'hB2, 8, 1'b1, 1'b1);
        chk("frame_b2_m", 32'(a_m), 32'hB2);
        chk("frame_b2_l", 32'(a_l), 32'h4D);
        chk("frame_b2_busy", 32'(busy_m), 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("frame_b2_valid_1cyc", 32'(av_m), 32'h0);

        // overrun: second word dropped while first is still pending
        send(8'hF0, 8, 1'b0, 1'b0);
        send(8'h0F, 8, 1'b0, 1'b0);
        chk("overrun_hold_a", 32'(a_m), 32'hF0);
        chk("overrun_flag", 32'(ovr_m), 32'h1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("overrun_drain", 32'(av_m), 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("overrun_clear", 32'(ovr_m), 32'h0);

        // mid-frame sof
        send(8'hFF, 5, 1'b1, 1'b1);
        send(8'h3C, 8, 1'b1, 1'b1);
        chk("frame_err_flag", 32'(fe_m), 32'h1);
        chk("frame_err_word", 32'(a_m), 32'h3C);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

        // pending word replaced on the edge it is accepted
        send(8'hAA, 8, 1'b0, 1'b0);
        send(8'h55, 8, 1'b0, 1'b1);
        chk("replace_word", 32'(a_m), 32'h55);
        chk("replace_valid", 32'(av_m), 32'h1);
        chk("replace_no_ovr", 32'(ovr_m), 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // reset mid-frame, then unframed bits are ignored
        send(8'hAA, 8, 1'b0, 1'b0);
        send(8'hC3, 4, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("midreset_a", 32'(a_m), 32'hF0);
        chk("midreset_valid", 32'(av_m), 32'h0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ignore_no_sof", 32'(cnt_m), 32'h0);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 9) < 7), 1'($urandom), ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 199) == 0));
        end

        chk("scoreboard_empty", 32'(qm.size() + ql.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_loader.md
# shift_loader

Serial-to-parallel front end for the `shift` datapath: collects a framed single-bit stream into an 8-bit word and presents it as the `a` operand of `shift` with a valid/ready handshake. It sits directly upstream of `shift`, replacing the free-running per-cycle random drive of `a` with deterministic, framed word delivery. Partial frames and lost words are detected and flagged in sticky status bits.

## Interface
- `WIDTH`, 8: word width; equals the `a` width of `shift`.
- `MSB_FIRST`, 1: 1 = first received bit lands in bit WIDTH-1; 0 = first bit lands in bit 0.
- `RESET_VAL`, 8'b11110000: value of `a` after reset.

- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `din` in 1: serial data bit, sampled only when `din_valid`=1.
- `din_valid` in 1: qualifies `din` for the current cycle.
- `sof` in 1: start of frame; meaningful only with `din_valid`=1; marks `din` as the frame's first bit.
- `a_ready` in 1: downstream accepts `a` when `a_valid`=1 and `a_ready`=1.
- `err_clr` in 1: clears `overrun` and `frame_err`.
- `a` out WIDTH: assembled word, registered, stable while `a_valid`=1; connects to `shift.a`.
- `a_valid` out 1: word pending.
- `busy` out 1: frame in progress (state SHIFT).
- `bit_cnt` out $clog2(WIDTH+1): bits collected in the current frame.
- `overrun` out 1: sticky; a completed word was dropped.
- `frame_err` out 1: sticky; `sof` arrived mid-frame.

## Operation
- State machine, 2 states:
  - IDLE: `din_valid` without `sof` is ignored. On `din_valid`&`sof`: load the bit as bit 1 of the frame, set `bit_cnt`=1, go to SHIFT.
  - SHIFT: each `din_valid` bit shifts in and increments `bit_cnt`. When `bit_cnt` reaches WIDTH, the word completes, `bit_cnt`=0, and the state returns to IDLE.
  - SHIFT with `din_valid`&`sof`: set `frame_err`, discard the partial word, restart with this bit as bit 1 (`bit_cnt`=1), stay in SHIFT.
- Shift direction:
  - MSB_FIRST=1: `sreg <= {sreg[WIDTH-2:0], din}`.
  - MSB_FIRST=0: `sreg <= {din, sreg[WIDTH-1:1]}`.
  - The shift register is internal and separate from `a`.
- Word completion:
  - If `a_valid`=0, or `a_ready`=1 in the same cycle: `a` <= completed word, `a_valid`=1.
  - Else: `a` is unchanged, the new word is dropped, and `overrun` is set.
- Handshake: `a_valid` falls on the edge where `a_valid`&`a_ready`, unless a word completes on that same edge; then `a_valid` stays 1 and `a` takes the new word.
- `err_clr` clears both sticky flags. If a set event occurs on the same edge as `err_clr`, the set wins.
- WIDTH=1 is legal: every `sof` bit completes a word immediately and the state stays IDLE.

## Timing
- Reset values on the edge where `rst`=1:
  - `a`=RESET_VAL, `a_valid`=0, `busy`=0, `bit_cnt`=0, `overrun`=0, `frame_err`=0.
  - State IDLE; shift register cleared to 0.
- Reset mid-frame discards the partial word and any pending word.
- Latency: last bit sampled at edge k gives `a`/`a_valid` updated at edge k, visible in cycle k+1.
- Minimum frame time is WIDTH cycles, so back-to-back frames yield one word per WIDTH cycles with no gap cycle required.
- `busy` and `bit_cnt` are registered and reflect the state after each edge.
- `a` never changes while `a_valid`=1 and `a_ready`=0.

## Test plan
- Reset, then `sof`+bits 1,0,1,1,0,0,1,0 on 8 consecutive cycles, MSB_FIRST=1, `a_ready`=1 → `a`=8'hB2, `a_valid` high for exactly 1 cycle, `busy` low after the last bit.
- Same stream with MSB_FIRST=0 → `a`=8'h4D.
- Frame 8'hF0 completes with `a_ready`=0, then a second frame 8'h0F completes → `a` holds 8'hF0, `overrun`=1. Raise `a_ready` → `a_valid` drops; pulse `err_clr` → `overrun`=0.
- `sof` with 5 bits, then a new `sof` and 8 bits of 8'h3C → `frame_err`=1, `a`=8'h3C, `bit_cnt` sequence restarts at 1.
- Pending word 8'hAA with `a_ready`=1 on the same edge that 8'h55 completes → `a`=8'h55, `a_valid` stays 1, `overrun`=0.
- Assert `rst` after 4 bits of a frame → next cycle `a`=8'hF0, all other outputs 0; `din_valid` without `sof` is then ignored (`bit_cnt` stays 0).
